alu_operand_stage: RTL and testbench

Operand-issue pipeline stage directly upstream of the 8-bit add/subtract unit. Holds an 8-entry × 8-bit register file with one writeback port. On each accepted issue it reads two operands, applies the subtract transform and registers `a`, `b` and `cin` for the combinational `AddSub_8bit` in the execute stage. Writeback from downstream is bypassed into same-cycle reads, and a valid/ready handshake stalls issue while execute is busy.

---
 rtl/alu_operand_stage.sv | 104 ++++++++++
 tb/tb_alu_operand_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-issue stage for the 8-bit add/subtract unit: register file with bypassed
// writeback, subtract transform, and a single-entry valid/ready output register.
module alu_operand_stage #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [2:0]        rs1,
   input  logic [2:0]        rs2,
   input  logic [2:0]        rd,
   input  logic              op_sub,
   input  logic              imm_en,
   input  logic [DATA_W-1:0] imm,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic              ex_cin,
   output logic [2:0]        ex_rd,
   input  logic              wb_en,
   input  logic [2:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t            state_p1, state_nxt;
   logic [DATA_W-1:0] regs [NREGS];
   logic [DATA_W-1:0] a_p0, rs2_val_p0, b_p0;
   logic              fire_p0;

   function automatic logic [DATA_W-1:0] sub_xform(input logic [DATA_W-1:0] b,
                                                   input logic              sub);
      return sub ? ~b : b;
   endfunction

   function automatic logic [DATA_W-1:0] read_bypass(input logic [2:0]        addr,
                                                     input logic [DATA_W-1:0] stored,
                                                     input logic              we,
                                                     input logic [2:0]        waddr,
                                                     input logic [DATA_W-1:0] wdata);
      if (addr == 3'd0)
         return '0;
      if (we && (waddr == addr))
         return wdata;
      return stored;
   endfunction

   // p0: register read with writeback bypass, operand B select and subtract transform
   always_comb begin
      a_p0       = read_bypass(rs1, regs[rs1], wb_en, wb_addr, wb_data);
      rs2_val_p0 = read_bypass(rs2, regs[rs2], wb_en, wb_addr, wb_data);
      b_p0       = sub_xform(imm_en ? imm : rs2_val_p0, op_sub);
   end

   assign ex_valid    = (state_p1 == FULL);
   assign issue_ready = !ex_valid || ex_ready;
   assign fire_p0     = issue_valid && issue_ready;

   always_comb begin
      state_nxt = state_p1;
      case (state_p1)
         EMPTY:   if (fire_p0) state_nxt = FULL;
         FULL:    if (ex_ready && !fire_p0) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_p1 <= EMPTY;
      else
         state_p1 <= state_nxt;
   end

   // Writeback is accepted every cycle regardless of the issue handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wb_en && (wb_addr != 3'd0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // p1: operand register feeding the execute-stage adder
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_a   <= '0;
         ex_b   <= '0;
         ex_cin <= 1'b0;
         ex_rd  <= 3'd0;
      end else if (fire_p0) begin
         ex_a   <= a_p0;
         ex_b   <= b_p0;
         ex_cin <= op_sub;
         ex_rd  <= rd;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage.
module tb_alu_operand_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic       issue_valid, issue_ready;
   logic [2:0] rs1, rs2, rd;
   logic       op_sub, imm_en;
   logic [7:0] imm;
   logic       ex_valid, ex_ready;
   logic [7:0] ex_a, ex_b;
   logic       ex_cin;
   logic [2:0] ex_rd;
   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] sum;

   alu_operand_stage #(.DATA_W(8), .NREGS(8)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .rs1(rs1), .rs2(rs2), .rd(rd), .op_sub(op_sub), .imm_en(imm_en), .imm(imm),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_a(ex_a), .ex_b(ex_b), .ex_cin(ex_cin), .ex_rd(ex_rd),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid = 1'b0; rs1 = 3'd0; rs2 = 3'd0; rd = 3'd0;
      op_sub = 1'b0; imm_en = 1'b0; imm = 8'h00;
      ex_ready = 1'b1; wb_en = 1'b0; wb_addr = 3'd0; wb_data = 8'h00;
   endtask

   task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
      step();
      wb_en = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      n_checks++; if (ex_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", ex_valid); else n_pass++;
      n_checks++; if (ex_a !== 8'h00) $display("FAIL rst_a got %h want 00", ex_a); else n_pass++;
      n_checks++; if (ex_b !== 8'h00) $display("FAIL rst_b got %h want 00", ex_b); else n_pass++;
      n_checks++; if (ex_cin !== 1'b0) $display("FAIL rst_cin got %b want 0", ex_cin); else n_pass++;
      n_checks++; if (ex_rd !== 3'd0) $display("FAIL rst_rd got %0d want 0", ex_rd); else n_pass++;
      n_checks++; if (issue_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", issue_ready); else n_pass++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_add();
      write_reg(3'd1, 8'h05);
      write_reg(3'd2, 8'h03);
      issue_valid = 1'b1; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd5; op_sub = 1'b0; imm_en = 1'b0;
      step();
      issue_valid = 1'b0;
      n_checks++; if (ex_a !== 8'h05) $display("FAIL add_a got %h want 05", ex_a); else n_pass++;
      n_checks++; if (ex_b !== 8'h03) $display("FAIL add_b got %h want 03", ex_b); else n_pass++;
      n_checks++; if (ex_cin !== 1'b0) $display("FAIL add_cin got %b want 0", ex_cin); else n_pass++;
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL add_valid got %b want 1", ex_valid); else n_pass++;
      n_checks++; if (ex_rd !== 3'd5) $display("FAIL add_rd got %0d want 5", ex_rd); else n_pass++;
      step();
      n_checks++; if (ex_valid !== 1'b0) $display("FAIL drain_valid got %b want 0", ex_valid); else n_pass++;
      n_checks++; if (ex_a !== 8'h05) $display("FAIL drain_hold_a got %h want 05", ex_a); else n_pass++;
   endtask

   task automatic test_back_to_back_sub();
      issue_valid = 1'b1; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd1; op_sub = 1'b1;
      step();
      sum = 8'(ex_a + ex_b + 8'(ex_cin));
      n_checks++; if (ex_b !== 8'hFC) $display("FAIL sub_b got %h want fc", ex_b); else n_pass++;
      n_checks++; if (ex_cin !== 1'b1) $display("FAIL sub_cin got %b want 1", ex_cin); else n_pass++;
      n_checks++; if (sum !== 8'h02) $display("FAIL sub_sum got %h want 02", sum); else n_pass++;
      rs1 = 3'd2; rs2 = 3'd1; rd = 3'd2;
      step();
      issue_valid = 1'b0; op_sub = 1'b0;
      sum = 8'(ex_a + ex_b + 8'(ex_cin));
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", ex_valid); else n_pass++;
      n_checks++; if (ex_b !== 8'hFA) $display("FAIL neg_b got %h want fa", ex_b); else n_pass++;
      n_checks++; if (sum !== 8'hFE) $display("FAIL neg_sum got %h want fe", sum); else n_pass++;
      n_checks++; if (ex_rd !== 3'd2) $display("FAIL neg_rd got %0d want 2", ex_rd); else n_pass++;
      step();
   endtask

   task automatic test_bypass_r0();
      wb_en = 1'b1; wb_addr = 3'd4; wb_data = 8'h7F;
      issue_valid = 1'b1; rs1 = 3'd4; rs2 = 3'd0; op_sub = 1'b0;
      step();
      n_checks++; if (ex_a !== 8'h7F) $display("FAIL byp_a got %h want 7f", ex_a); else n_pass++;
      n_checks++; if (ex_b !== 8'h00) $display("FAIL byp_r0_b got %h want 00", ex_b); else n_pass++;
      wb_addr = 3'd6; wb_data = 8'h33; rs1 = 3'd6; rs2 = 3'd6;
      step();
      n_checks++; if (ex_a !== 8'h33) $display("FAIL byp_both_a got %h want 33", ex_a); else n_pass++;
      n_checks++; if (ex_b !== 8'h33) $display("FAIL byp_both_b got %h want 33", ex_b); else n_pass++;
      wb_en = 1'b0; rs1 = 3'd4; rs2 = 3'd6;
      step();
      n_checks++; if (ex_a !== 8'h7F) $display("FAIL stored_a got %h want 7f", ex_a); else n_pass++;
      n_checks++; if (ex_b !== 8'h33) $display("FAIL stored_b got %h want 33", ex_b); else n_pass++;
      wb_en = 1'b1; wb_addr = 3'd0; wb_data = 8'hAA; rs1 = 3'd0; rs2 = 3'd0;
      step();
      n_checks++; if (ex_a !== 8'h00) $display("FAIL r0_byp_a got %h want 00", ex_a); else n_pass++;
      wb_en = 1'b0;
      step();
      issue_valid = 1'b0;
      n_checks++; if (ex_a !== 8'h00) $display("FAIL r0_stored_a got %h want 00", ex_a); else n_pass++;
      n_checks++; if (ex_b !== 8'h00) $display("FAIL r0_stored_b got %h want 00", ex_b); else n_pass++;
      step();
   endtask

   task automatic test_backpressure();
      ex_ready = 1'b0;
      issue_valid = 1'b1; rs1 = 3'd1; imm_en = 1'b1; imm = 8'h80; op_sub = 1'b0; rd = 3'd3;
      step();
      rs1 = 3'd2; imm = 8'h11; op_sub = 1'b1; rd = 3'd7;
      #1;
      n_checks++; if (issue_ready !== 1'b0) $display("FAIL bp_ready got %b want 0", issue_ready); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++; if (ex_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", i, ex_valid); else n_pass++;
         n_checks++; if (issue_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b want 0", i, issue_ready); else n_pass++;
         n_checks++; if ({ex_a, ex_b, ex_cin, ex_rd} !== {8'h05, 8'h80, 1'b0, 3'd3})
            $display("FAIL bp_hold[%0d] got a=%h b=%h cin=%b rd=%0d want a=05 b=80 cin=0 rd=3", i, ex_a, ex_b, ex_cin, ex_rd);
         else n_pass++;
      end
      ex_ready = 1'b1;
      #1;
      n_checks++; if (issue_ready !== 1'b1) $display("FAIL bp_release_ready got %b want 1", issue_ready); else n_pass++;
      step();
      issue_valid = 1'b0; imm_en = 1'b0; op_sub = 1'b0;
      n_checks++; if ({ex_a, ex_b, ex_cin, ex_rd} !== {8'h03, 8'hEE, 1'b1, 3'd7})
         $display("FAIL bp_second got a=%h b=%h cin=%b rd=%0d want a=03 b=ee cin=1 rd=7", ex_a, ex_b, ex_cin, ex_rd);
      else n_pass++;
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL bp_second_valid got %b want 1", ex_valid); else n_pass++;
      step();
   endtask

   task automatic test_stream();
      ex_ready = 1'b1; issue_valid = 1'b1; rs1 = 3'd1; imm_en = 1'b1; op_sub = 1'b0;
      for (int i = 0; i <= 128; i++) begin
         imm = 8'(i);
         step();
         n_checks++; if (ex_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b want 1", i, ex_valid); else n_pass++;
         n_checks++; if (ex_b !== 8'(i) || ex_a !== 8'h05)
            $display("FAIL stream_data[%0d] got a=%h b=%h want a=05 b=%h", i, ex_a, ex_b, 8'(i));
         else n_pass++;
      end
      issue_valid = 1'b0; imm_en = 1'b0;
      step();
   endtask

   task automatic test_reset_full();
      ex_ready = 1'b0; issue_valid = 1'b1; rs1 = 3'd1; rs2 = 3'd2; op_sub = 1'b1; rd = 3'd4;
      step();
      issue_valid = 1'b0;
      n_checks++; if (ex_valid !== 1'b1) $display("FAIL rf_full_valid got %b want 1", ex_valid); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (ex_valid !== 1'b0) $display("FAIL rf_async_valid got %b want 0", ex_valid); else n_pass++;
      n_checks++; if ({ex_a, ex_b, ex_cin} !== {8'h00, 8'h00, 1'b0})
         $display("FAIL rf_async_data got a=%h b=%h cin=%b want a=00 b=00 cin=0", ex_a, ex_b, ex_cin);
      else n_pass++;
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 8'h99;
      step();
      wb_en = 1'b0; rst = 1'b0;
      ex_ready = 1'b1; issue_valid = 1'b1; rs1 = 3'd1; rs2 = 3'd2; op_sub = 1'b0;
      step();
      issue_valid = 1'b0;
      n_checks++; if (ex_a !== 8'h00) $display("FAIL rf_reg1_cleared got %h want 00", ex_a); else n_pass++;
      n_checks++; if (ex_b !== 8'h00) $display("FAIL rf_wb_lost got %h want 00", ex_b); else n_pass++;
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back_sub();
      test_bypass_r0();
      test_backpressure();
      test_stream();
      test_reset_full();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
